// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arb_pkg
//  Purpose : Shared types and default constants for the data-memory arbiter.
//            - arb_state_t : arbiter FSM state encoding
//            - owner_t     : identity of a memory owner (CPU or DMA)
//            - MAX_BURST_DEF : default burst length before forced handover
//  Ports   : none (package)
//  Config  : the arbiter honours macro DMEM_ARB_CPU_PRIO_EN (fixed CPU
//            priority); nothing in this package depends on it.
//  Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int unsigned MAX_BURST_DEF = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/arb_burst_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : arb_burst_cnt
//  Purpose : Clearable, saturating beat counter used by dmem_arbiter to
//            measure how many consecutive beats the current owner has taken.
//  Ports   : clk      - clock, rising edge
//            reset    - synchronous, active-high; clears the count
//            clr_i    - clear request (ownership change); wins over inc_i
//            inc_i    - one beat occurred this cycle
//            count_o  - current beat count, saturates at MAX_BURST
//  Config  : none (macro DMEM_ARB_CPU_PRIO_EN is handled in dmem_arbiter)
//  Revision: 1.0 - initial release
// ============================================================================
module arb_burst_cnt
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A clear coincides with the beat that caused the handover (if any); that
  // beat belongs to the old owner, so the new owner starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule : arb_burst_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Two-requester (CPU / DMA) arbiter in front of a single-port data
//            memory with combinational read data. Ownership is held in a
//            three-state FSM; grants are registered-state decodes so there
//            is no combinational path from any request to a grant.
//            Default build: round-robin ties and forced handover after
//            MAX_BURST consecutive beats when the other side is waiting.
//  Config  : `define DMEM_ARB_CPU_PRIO_EN -> fixed CPU priority: ties go to
//            the CPU and the CPU is never forced off; the DMA is still
//            preempted after MAX_BURST beats when the CPU is waiting.
//  Ports   : clk, reset                       - clock / sync active-high reset
//            cpu_req/we/addr/wd               - CPU access request
//            cpu_gnt, cpu_stall, cpu_rd       - CPU grant, stall, read data
//            dma_req/we/addr/wd               - DMA access request
//            dma_gnt, dma_rd                  - DMA grant, read data
//            mem_we, mem_addr, mem_wd, mem_rd - data-memory port
//  Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rd,
  // DMA side
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wd,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rd,
  // Memory side
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  // The beat count at which the current beat completes a full burst. Once
  // saturated the count sits at MAX_BURST, which also satisfies ">=".
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam bit CPU_PRIO = 1'b1;
`else
  localparam bit CPU_PRIO = 1'b0;
`endif

  arb_state_t       state_q;
  arb_state_t       state_d;
  owner_t           rr_last_q;
  owner_t           rr_last_d;

  logic             cpu_own;
  logic             dma_own;
  logic             beat;
  logic             burst_done;
  logic             state_chg;
  logic [CNT_W-1:0] beat_cnt;

  // --------------------------------------------------------------------------
  // Ownership decode. Reset masks ownership immediately so a reset raised in
  // the middle of a burst kills the write strobe in that very cycle, before
  // the synchronous state reset has taken effect.
  // --------------------------------------------------------------------------
  assign cpu_own = (state_q == ARB_CPU) && !reset;
  assign dma_own = (state_q == ARB_DMA) && !reset;

  assign beat       = (cpu_own && cpu_req) || (dma_own && dma_req);
  assign burst_done = (beat_cnt >= CNT_LAST);
  assign state_chg  = (state_d != state_q);

  // --------------------------------------------------------------------------
  // Beat counter: counts consecutive beats of the current owner.
  // --------------------------------------------------------------------------
  arb_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_chg),
    .inc_i   (beat),
    .count_o (beat_cnt)
  );

  // --------------------------------------------------------------------------
  // FSM next-state logic.
  // An owner dropping its request hands over directly to a waiting peer (no
  // idle bubble). A forced handover only happens on a beat that finishes the
  // burst, so the last beat is taken exactly once before ownership moves.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;

    case (state_q)
      ARB_IDLE: begin
        if (cpu_req && dma_req) begin
          if (CPU_PRIO || (rr_last_q == OWN_DMA)) begin
            state_d = ARB_CPU;
          end else begin
            state_d = ARB_DMA;
          end
        end else if (cpu_req) begin
          state_d = ARB_CPU;
        end else if (dma_req) begin
          state_d = ARB_DMA;
        end
      end

      ARB_CPU: begin
        if (!cpu_req) begin
          state_d = dma_req ? ARB_DMA : ARB_IDLE;
        end else if (!CPU_PRIO && burst_done && dma_req) begin
          state_d = ARB_DMA;
        end
      end

      ARB_DMA: begin
        // The DMA is preemptable after a full burst in both build flavours.
        if (!dma_req) begin
          state_d = cpu_req ? ARB_CPU : ARB_IDLE;
        end else if (burst_done && cpu_req) begin
          state_d = ARB_CPU;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // rr_last remembers who was granted most recently, updated on entry.
    if (state_chg) begin
      if (state_d == ARB_CPU) begin
        rr_last_d = OWN_CPU;
      end else if (state_d == ARB_DMA) begin
        rr_last_d = OWN_DMA;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers. rr_last resets to DMA so the CPU wins the first tie.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rr_last_q <= OWN_DMA;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The memory port is driven by the owner only; with no owner it
  // is parked at all-zero. Read data is steered to the owner, zero otherwise.
  // --------------------------------------------------------------------------
  assign cpu_gnt   = cpu_own;
  assign dma_gnt   = dma_own;
  assign cpu_stall = cpu_req && !cpu_own;

  assign mem_we = (cpu_own && cpu_req && cpu_we) ||
                  (dma_own && dma_req && dma_we);

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_own) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (dma_own) begin
      mem_addr = dma_addr;
      mem_wd   = dma_wd;
    end
  end

  assign cpu_rd = cpu_own ? mem_rd : '0;
  assign dma_rd = dma_own ? mem_rd : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Purpose : Directed self-checking bench for dmem_arbiter (MAX_BURST = 4).
//            Inputs change 1 time unit after each rising edge; outputs are
//            checked 1-2 time units later, well away from the next edge.
//            The memory is modelled as mem_rd = mem_addr ^ 32'hA5A5_0000.
//  Config  : checks follow the build flavour selected by
//            DMEM_ARB_CPU_PRIO_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
  logic        cpu_gnt, cpu_stall, dma_gnt, mem_we;
  logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd, mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem_addr ^ 32'hA5A5_0000;

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_gnt   (cpu_gnt),
    .cpu_stall (cpu_stall),
    .cpu_rd    (cpu_rd),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wd    (dma_wd),
    .dma_gnt   (dma_gnt),
    .dma_rd    (dma_rd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    cpu_req  = 1'b1;
    dma_req  = 1'b1;
    cpu_we   = 1'b0;
    dma_we   = 1'b0;
    cpu_addr = 32'h0;
    cpu_wd   = 32'h0;
    dma_addr = 32'h0;
    dma_wd   = 32'h0;
    #2;

    // Reset held for three edges with both requests high.
    for (int i = 0; i < 3; i++) begin
      chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1("rst_dma_gnt", dma_gnt, 1'b0);
      chk1("rst_mem_we",  mem_we,  1'b0);
      nxt();
    end

    // Release: still idle this cycle, CPU wins the first tie next cycle.
    reset = 1'b0;
    #1;
    chk1("post_rst_wait_gnt",   cpu_gnt,   1'b0);
    chk1("post_rst_wait_stall", cpu_stall, 1'b1);
    nxt();

`ifdef DMEM_ARB_CPU_PRIO_EN
    // Fixed priority: CPU keeps the memory for the whole contention window.
    for (int i = 0; i < 12; i++) begin
      chk1("prio_cpu_gnt",   cpu_gnt,   1'b1);
      chk1("prio_dma_gnt",   dma_gnt,   1'b0);
      chk1("prio_cpu_stall", cpu_stall, 1'b0);
      nxt();
    end
`else
    // Round robin: 4 CPU beats, 4 DMA beats, back to CPU with no idle cycle.
    for (int i = 0; i < 4; i++) begin
      chk1("rr_cpu_gnt", cpu_gnt, 1'b1);
      chk1("rr_cpu_dma", dma_gnt, 1'b0);
      nxt();
    end
    for (int i = 0; i < 4; i++) begin
      chk1("rr_dma_gnt",   dma_gnt,   1'b1);
      chk1("rr_dma_cpu",   cpu_gnt,   1'b0);
      chk1("rr_cpu_stall", cpu_stall, 1'b1);
      nxt();
    end
    chk1("rr_back_cpu", cpu_gnt, 1'b1);
`endif

    // Both drop: no beat in this cycle, then idle with a parked memory port.
    cpu_req = 1'b0;
    dma_req = 1'b0;
    #1;
    chk1("drop_mem_we", mem_we, 1'b0);
    nxt();
    chk1 ("idle_cpu_gnt",  cpu_gnt,  1'b0);
    chk1 ("idle_dma_gnt",  dma_gnt,  1'b0);
    chk32("idle_mem_addr", mem_addr, 32'h0);
    chk32("idle_cpu_rd",   cpu_rd,   32'h0);

    // CPU-only write to 0x10.
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 32'h10;
    cpu_wd   = 32'h55;
    #1;
    chk1 ("wr_wait_stall", cpu_stall, 1'b1);
    chk1 ("wr_wait_gnt",   cpu_gnt,   1'b0);
    chk1 ("wr_wait_we",    mem_we,    1'b0);
    chk32("wr_wait_wd",    mem_wd,    32'h0);
    nxt();
    chk1 ("wr_gnt",   cpu_gnt,   1'b1);
    chk1 ("wr_we",    mem_we,    1'b1);
    chk32("wr_addr",  mem_addr,  32'h10);
    chk32("wr_wd",    mem_wd,    32'h55);
    chk1 ("wr_stall", cpu_stall, 1'b0);

    // CPU drops while owner with DMA waiting: direct handover to DMA read.
    nxt();
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 32'h800;
    #1;
    chk1("ho_drop_gnt", cpu_gnt, 1'b1);
    chk1("ho_drop_we",  mem_we,  1'b0);
    nxt();
    chk1 ("ho_dma_gnt",  dma_gnt,  1'b1);
    chk1 ("ho_cpu_gnt",  cpu_gnt,  1'b0);
    chk32("ho_mem_addr", mem_addr, 32'h800);
    chk32("ho_dma_rd",   dma_rd,   32'hA5A5_0800);
    chk32("ho_cpu_rd",   cpu_rd,   32'h0);
    chk1 ("ho_mem_we",   mem_we,   1'b0);

    // DMA write burst; reset lands on its 2nd write beat.
    nxt();
    dma_we   = 1'b1;
    dma_addr = 32'h804;
    dma_wd   = 32'hCAFE;
    #1;
    chk1 ("dwr1_we",  mem_we,  1'b1);
    chk32("dwr1_wd",  mem_wd,  32'hCAFE);
    chk1 ("dwr1_gnt", dma_gnt, 1'b1);
    nxt();
    dma_wd = 32'hBEEF;
    reset  = 1'b1;
    #1;
    chk1("dwr2_rst_we", mem_we, 1'b0);
    nxt();
    reset = 1'b0;
    #1;
    chk1("dwr_after_rst_gnt", dma_gnt, 1'b0);
    chk1("dwr_after_rst_we",  mem_we,  1'b0);
    nxt();
    chk1 ("post_rst2_dma_gnt", dma_gnt, 1'b1);
    chk1 ("post_rst2_we",      mem_we,  1'b1);
    chk32("post_rst2_wd",      mem_wd,  32'hBEEF);

    // DMA drops with CPU waiting: direct handover to CPU, which then holds
    // the memory alone long enough for its beat count to saturate.
    dma_req  = 1'b0;
    dma_we   = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h20;
    #1;
    chk1("dma_drop_we", mem_we, 1'b0);
    nxt();
    for (int i = 0; i < 6; i++) begin
      chk1("sat_cpu_gnt", cpu_gnt, 1'b1);
      chk1("sat_dma_gnt", dma_gnt, 1'b0);
      nxt();
    end

    // DMA arrives while the CPU count is saturated.
    dma_req = 1'b1;
    #1;
    chk1 ("sat_arrive_gnt",  cpu_gnt,  1'b1);
    chk32("sat_arrive_addr", mem_addr, 32'h20);
    chk32("sat_arrive_rd",   cpu_rd,   32'hA5A5_0020);
    nxt();
`ifdef DMEM_ARB_CPU_PRIO_EN
    chk1("sat_prio_cpu_gnt", cpu_gnt, 1'b1);
    chk1("sat_prio_dma_gnt", dma_gnt, 1'b0);
`else
    chk1("sat_rr_dma_gnt",   dma_gnt,   1'b1);
    chk1("sat_rr_cpu_gnt",   cpu_gnt,   1'b0);
    chk1("sat_rr_cpu_stall", cpu_stall, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
